uart_rx_sync: RTL
=================

UART_RX_SYNC -- requirements
Module: uart_rx_sync

Interface
REQ-001 Parameter clk_freq, default 100000, system clock frequency in Hz.
REQ-002 Parameter baud_rate, default 9600, line bit rate; CLKS_PER_BIT = clk_freq/baud_rate (integer, 10 at defaults), elaboration error if < 4.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 rx  input  1  asynchronous serial line, idle high, 8N1 frames (8E1 with parity macro), LSB first.
REQ-006 rx_data  output  8  received byte holding register.
REQ-007 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-008 rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
REQ-009 frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 parity_err  output  1  one-cycle pulse, parity mismatch; constant 0 without the parity macro.
REQ-011 overrun  output  1  one-cycle pulse, good byte completed while rx_valid still high.

Function
REQ-012 rx shall pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s (2-cycle latency).
REQ-013 States: IDLE, START, DATA, PARITY (macro only), STOP; one bit-cycle counter 0..CLKS_PER_BIT-1, one bit index 0..7.
REQ-014 IDLE: arm flag set once rx_s seen high; armed and rx_s==0 -> START, counter cleared; unarmed low line never starts a frame (break/stuck-low protection).
REQ-015 START: at counter == CLKS_PER_BIT/2-1 sample rx_s; 0 -> DATA with counter and index cleared; 1 -> IDLE (glitch rejected, no output activity).
REQ-016 DATA: sample rx_s every CLKS_PER_BIT cycles (mid-bit), shift into a shift register LSB first; after index 7 -> PARITY if compiled in, else STOP.
REQ-017 STOP: sample after CLKS_PER_BIT cycles; then -> IDLE with arm flag cleared.
REQ-018 Stop sampled 1 and no parity error: byte is good; stop sampled 0: frame_err pulses the next cycle, byte discarded.
REQ-019 Good byte with rx_valid==0: rx_data loaded, rx_valid=1 the cycle after the stop sample.
REQ-020 Good byte with rx_valid==1 and no handshake that cycle: overrun pulses, new byte dropped, old rx_data/rx_valid unchanged.
REQ-021 Good byte in the same cycle as a handshake: new byte loaded, rx_valid stays 1, no overrun.
REQ-022 Handshake with no new byte: rx_valid cleared next cycle; rx_data retains last value.
REQ-023 Error pulses shall be mutually exclusive per frame; parity error takes priority over framing error.

Reset
REQ-024 rst==0 at a clock edge: state IDLE, arm flag 0, counters 0, synchronizer flops 1, rx_data 8'h00, rx_valid/frame_err/parity_err/overrun 0.
REQ-025 Reset mid-frame shall abandon the frame with no output pulse; reception resumes with the first armed falling edge after release.

Configuration
REQ-026 Macro UART_RX_PARITY_EN: defined -> even parity bit after data, sampled in PARITY like a data bit, mismatch pulses parity_err and discards byte; undefined -> no PARITY state, parity_err tied 0.

Structure
REQ-027 Package uart_pkg holds the rx state enum typedef and the CLKS_PER_BIT computation function; shared with the transmitter.
REQ-028 Sub-module uart_sync2 (2-flop synchronizer, reset value 1) instantiated once on rx.

Verification (clk_freq 100000, baud_rate 9600, 10 clk/bit)
REQ-029 Frame 0xA5, rx_ready=1 -> rx_valid one cycle with rx_data=8'hA5, all error pulses 0.
REQ-030 rx low for 3 clocks then high -> no rx_valid, no error pulse, state returns IDLE.
REQ-031 Frame 0x3C with stop bit 0, line held low 30 clocks, then frame 0x81 -> one frame_err pulse, no start during the low hold, then rx_data=8'h81 valid.
REQ-032 Frames 0x11 then 0x22, rx_ready=0 -> rx_data stays 8'h11, rx_valid 1, one overrun pulse at second stop sample.
REQ-033 rst=0 for 2 clocks during bit 3 of 0x5A, then clean 0x5A -> outputs reset values, no pulses, then rx_data=8'h5A valid.
REQ-034 UART_RX_PARITY_EN defined, frame 0x07 with parity bit 0 -> one parity_err pulse, rx_valid stays 0; parity bit 1 -> rx_data=8'h07 valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-period computation.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Whole clock cycles per bit; fractional remainder is dropped.
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input. Reset value is 1,
// which matches the idle level of a UART line.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // NOTE: synchronous active-low reset -- rst is only looked at on the clock edge,
  // so it sits inside the edge-triggered block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/uart_rx_sync.sv
// UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined), mid-bit sampling,
// single-entry holding register with valid/ready handshake and error pulses.
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int clk_freq  = 100000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = clks_per_bit(clk_freq, baud_rate);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_cfg
      $error("uart_rx_sync: clk_freq/baud_rate must be at least 4");
    end
  endgenerate

  rx_state_t        r_state;
  logic             r_armed;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
  logic             r_frame_err;
  logic             r_overrun;
  logic             w_rx_s;
  logic             w_bit_end;
  logic             w_par_fail;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (w_rx_s)
  );

  assign w_bit_end = (r_cnt == CNT_LAST);

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_parity_err;
  assign w_par_fail = r_par_bad;
  assign parity_err = r_parity_err;
`else
  assign w_par_fail = 1'b0;
  assign parity_err = 1'b0;
`endif

  // NOTE: every register here is assigned with <= so all of them update together
  // from the values present before the edge; blocking = would leak new values downstream.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= RX_IDLE;
      r_armed     <= 1'b0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;

      case (r_state)
        RX_IDLE: begin
          // A line that has never been seen high since the last frame cannot start one.
          if (w_rx_s) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end

        RX_START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_state <= w_rx_s ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        RX_DATA: begin
          if (w_bit_end) begin
            r_shift <= {w_rx_s, r_shift[7:1]};
            r_cnt   <= '0;
            if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= RX_PARITY;
`else
              r_state <= RX_STOP;
`endif
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (w_bit_end) begin
            r_par_bad <= ^{w_rx_s, r_shift};
            r_cnt     <= '0;
            r_state   <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif

        RX_STOP: begin
          if (w_bit_end) begin
            r_state <= RX_IDLE;
            r_armed <= 1'b0;
            r_cnt   <= '0;
            if (w_par_fail) begin
`ifdef UART_RX_PARITY_EN
              r_parity_err <= 1'b1;
`endif
            end else if (!w_rx_s) begin
              r_frame_err <= 1'b1;
            end else if (!r_rx_valid || rx_ready) begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
